// File: rtl/nes_clk_en_gen.sv
// NES clock-enable generator: NUM_CH divided CE strobes plus a stretched reset.
// Define CLKGEN_PHASE_OUT_EN to expose the live channel counters on PHASE_OUT.
module nes_clk_en_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {8'd6, 8'd3, 8'd2},
  parameter int RST_STRETCH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic                    ENABLE,
  input  logic [NUM_CH*CNT_W-1:0] DIV_IN,
  input  logic                    DIV_LOAD,
  output logic [NUM_CH-1:0]       CE_OUT,
  output logic                    ALIGN,
  output logic                    RESET_OUT,
`ifdef CLKGEN_PHASE_OUT_EN
  output logic                    LOCKED,
  output logic [NUM_CH*CNT_W-1:0] PHASE_OUT
`else
  output logic                    LOCKED
`endif
);

  localparam int ST_W = $clog2(RST_STRETCH + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(RST_STRETCH - 1);

  logic [1:0]                   sync_q;
  logic                         run;
  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            ce_q, ce_d;
  logic                         align_q, align_d;
  logic [ST_W-1:0]              st_q, st_d;
  logic                         rst_out_q, rst_out_d;
  logic                         locked_q, locked_d;

  // A divisor of 0 behaves as 1, so the terminal count is 0 as well.
  function automatic logic [CNT_W-1:0] last_cnt(
    input logic [CNT_W-1:0] d
  );
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = sync_q[1] & ENABLE;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    ce_d  = '0;
    if (DIV_LOAD) begin
      div_d = DIV_IN;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (DIV_LOAD) begin
        cnt_d[i] = '0;
      end else if (run) begin
        if (cnt_q[i] >= last_cnt(div_q[i])) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    align_d = &ce_d;
  end

  // Stretch counter freezes once the downstream reset has released.
  always_comb begin
    st_d      = st_q;
    rst_out_d = rst_out_q;
    locked_d  = locked_q;
    if (sync_q[1] && !locked_q) begin
      st_d = st_q + ST_W'(1);
      if (st_q == ST_LAST) begin
        rst_out_d = 1'b0;
        locked_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      div_q     <= DEF_DIV;
      cnt_q     <= '0;
      ce_q      <= '0;
      align_q   <= 1'b0;
      st_q      <= '0;
      rst_out_q <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      align_q   <= align_d;
      st_q      <= st_d;
      rst_out_q <= rst_out_d;
      locked_q  <= locked_d;
    end
  end

  assign CE_OUT    = ce_q;
  assign ALIGN     = align_q;
  assign RESET_OUT = rst_out_q;
  assign LOCKED    = locked_q;

`ifdef CLKGEN_PHASE_OUT_EN
  assign PHASE_OUT = cnt_q;
`endif

endmodule

// File: tb/tb_nes_clk_en_gen.sv
// Directed bench for nes_clk_en_gen: reset stretch, ratios, reload,
// pause, async reset; PHASE_OUT checked when CLKGEN_PHASE_OUT_EN is set.
module tb_nes_clk_en_gen;

  localparam int DW = 24;

  logic          CLK = 1'b0;
  logic          RESET_n = 1'b0;
  logic          ENABLE = 1'b0;
  logic          DIV_LOAD = 1'b0;
  logic [DW-1:0] DIV_IN = '0;
  logic [2:0]    CE_OUT;
  logic          ALIGN;
  logic          RESET_OUT;
  logic          LOCKED;
`ifdef CLKGEN_PHASE_OUT_EN
  logic [DW-1:0] PHASE_OUT;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  nes_clk_en_gen dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .ENABLE   (ENABLE),
    .DIV_IN   (DIV_IN),
    .DIV_LOAD (DIV_LOAD),
    .CE_OUT   (CE_OUT),
    .ALIGN    (ALIGN),
    .RESET_OUT(RESET_OUT),
`ifdef CLKGEN_PHASE_OUT_EN
    .LOCKED   (LOCKED),
    .PHASE_OUT(PHASE_OUT)
`else
    .LOCKED   (LOCKED)
`endif
  );

  typedef struct {
    int         cyc;
    logic [2:0] ce;
    logic       ro;
    logic       lk;
  } vec_t;

  vec_t v1 [14];

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Packs {CE_OUT, ALIGN, RESET_OUT, LOCKED}; ALIGN must equal &CE_OUT.
  task automatic chk_cyc(input string nm, input logic [2:0] ce,
                         input logic ro, input logic lk);
    chk(nm, {26'd0, CE_OUT, ALIGN, RESET_OUT, LOCKED},
        {26'd0, ce, &ce, ro, lk});
  endtask

  // Expected CE pattern u cycles after counters start from zero.
  function automatic logic [2:0] base(input int u, input int d0,
                                      input int d1, input int d2);
    logic [2:0] r;
    r[0] = (u > 0) && (u % d0 == 0);
    r[1] = (u > 0) && (u % d1 == 0);
    r[2] = (u > 0) && (u % d2 == 0);
    return r;
  endfunction

  task automatic do_reset();
    RESET_n  = 1'b0;
    ENABLE   = 1'b1;
    DIV_LOAD = 1'b0;
    DIV_IN   = '0;
    repeat (5) tick();
    chk_cyc("reset_hold", 3'b000, 1'b1, 1'b0);
`ifdef CLKGEN_PHASE_OUT_EN
    chk("reset_phase", {8'd0, PHASE_OUT}, 32'd0);
`endif
    RESET_n = 1'b1;
    tick();
    tick();
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    v1[0]  = '{0,  3'b000, 1'b1, 1'b0};
    v1[1]  = '{1,  3'b000, 1'b1, 1'b0};
    v1[2]  = '{2,  3'b001, 1'b1, 1'b0};
    v1[3]  = '{3,  3'b010, 1'b1, 1'b0};
    v1[4]  = '{4,  3'b001, 1'b1, 1'b0};
    v1[5]  = '{5,  3'b000, 1'b1, 1'b0};
    v1[6]  = '{6,  3'b111, 1'b1, 1'b0};
    v1[7]  = '{9,  3'b010, 1'b1, 1'b0};
    v1[8]  = '{12, 3'b111, 1'b1, 1'b0};
    v1[9]  = '{15, 3'b010, 1'b1, 1'b0};
    v1[10] = '{16, 3'b001, 1'b0, 1'b1};
    v1[11] = '{17, 3'b000, 1'b0, 1'b1};
    v1[12] = '{18, 3'b111, 1'b0, 1'b1};
    v1[13] = '{19, 3'b000, 1'b0, 1'b1};

    // reset stretch and first pulses
    do_reset();
    for (int i = 0; i < 14; i++) begin
      while (cyc < v1[i].cyc) tick();
      chk_cyc($sformatf("t1_c%0d", v1[i].cyc), v1[i].ce, v1[i].ro,
              v1[i].lk);
    end

    // steady-state ratios
    tick();
    while (cyc < 60) begin
      chk_cyc("t2_ratio", base(cyc, 2, 3, 6), 1'b0, 1'b1);
`ifdef CLKGEN_PHASE_OUT_EN
      chk("t6_phase_ch1", {24'd0, PHASE_OUT[15:8]}, 32'(cyc % 3));
`endif
      tick();
    end

    // reload {4,0,1} captured at the edge starting cycle 20
    do_reset();
    while (cyc < 19) tick();
    chk_cyc("t3_pre", 3'b000, 1'b0, 1'b1);
    DIV_IN   = {8'd4, 8'd0, 8'd1};
    DIV_LOAD = 1'b1;
    tick();
    DIV_LOAD = 1'b0;
    while (cyc <= 40) begin
      chk_cyc("t3_reload",
              {cyc >= 24 && (cyc - 20) % 4 == 0, cyc >= 21, cyc >= 21},
              1'b0, 1'b1);
      tick();
    end

    // continuous load holds counters at zero
    DIV_IN   = {8'd6, 8'd3, 8'd2};
    DIV_LOAD = 1'b1;
    repeat (8) begin
      tick();
      chk_cyc("t3_hold", 3'b000, 1'b0, 1'b1);
    end
    DIV_LOAD = 1'b0;
    while (cyc < 62) begin
      tick();
      chk_cyc("t3_after", base(cyc - 49, 2, 3, 6), 1'b0, 1'b1);
    end

    // pause: ENABLE low at edges starting cycles 7..11
    do_reset();
    while (cyc < 6) begin
      chk_cyc("t4_pre", base(cyc, 2, 3, 6), 1'b1, 1'b0);
      tick();
    end
    chk_cyc("t4_c6", 3'b111, 1'b1, 1'b0);
    ENABLE = 1'b0;
    repeat (5) begin
      tick();
      chk_cyc("t4_pause", 3'b000, 1'b1, 1'b0);
    end
    ENABLE = 1'b1;
    while (cyc < 30) begin
      tick();
      chk_cyc("t4_resume", base(cyc - 5, 2, 3, 6), cyc < 16, cyc >= 16);
    end

    // load together with ENABLE low: load clears, no CE
    DIV_IN   = {8'd6, 8'd3, 8'd2};
    DIV_LOAD = 1'b1;
    ENABLE   = 1'b0;
    tick();
    chk_cyc("t4_ldpause", 3'b000, 1'b0, 1'b1);
    DIV_LOAD = 1'b0;
    repeat (2) begin
      tick();
      chk_cyc("t4_ldpause", 3'b000, 1'b0, 1'b1);
    end
    ENABLE = 1'b1;
    while (cyc < 45) begin
      tick();
      chk_cyc("t4_ldresume", base(cyc - 33, 2, 3, 6), 1'b0, 1'b1);
    end

    // async reset mid-run, divisors must revert
    do_reset();
    while (cyc < 19) tick();
    DIV_IN   = {8'd4, 8'd0, 8'd1};
    DIV_LOAD = 1'b1;
    tick();
    DIV_LOAD = 1'b0;
    while (cyc < 33) tick();
    chk_cyc("t5_pre", 3'b011, 1'b0, 1'b1);
    #2;
    RESET_n = 1'b0;
    #1;
    chk_cyc("t5_async", 3'b000, 1'b1, 1'b0);
    do_reset();
    while (cyc <= 12) begin
      chk_cyc("t5_default", base(cyc, 2, 3, 6), 1'b1, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
